md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
Issue and sequencing controller for the shared multiply/divide unit in the 5-stage pipeline.
- Accepts md-class operations from the EX stage.
- Pulses the unit's start and function select, and counts out the fixed operation latency.
- Produces busy, D-stage stall, and HI/LO write enables.
- Sits between the EX-stage controller and the multiply/divide datapath; the stall unit consumes its stall output.

Parameters:
MULT_LAT, 5, busy cycles for mult/multu (>=1)
DIV_LAT, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
e_op_valid  input  1  EX stage holds a valid md-class instruction this cycle
e_op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved
e_rt_zero  input  1  EX-stage forwarded rt operand equals 0
d_md_use  input  1  D-stage instruction is md-class (mult/div/mthi/mtlo/mfhi/mflo)
md_start  output  1  one-cycle start pulse to the multiply/divide datapath
md_func  output  3  operation code presented with md_start (copy of e_op), else 000
md_busy  output  1  operation in progress
d_stall  output  1  stall request for PC, IF/ID and ID/EX enables
hi_we  output  1  commit HI this cycle
lo_we  output  1  commit LO this cycle
md_done  output  1  one-cycle completion pulse for mult/div
md_cnt  output  CNT_W  remaining busy cycles, 0 when idle
md_err  output  1  sticky: issue attempted while busy, or reserved op

Behaviour:
- Reset (reset==0, asynchronous): state IDLE; md_cnt=0; md_err=0; all other outputs 0. Any in-flight operation is discarded with no hi_we/lo_we.
- States: IDLE, RUN.
- Accept: in IDLE with e_op_valid and e_op in 001..100 (cycle N):
  - md_start=1 and md_func=e_op, combinationally in cycle N.
  - At the edge, md_cnt loads LAT (MULT_LAT or DIV_LAT) and state goes to RUN.
- RUN:
  - md_busy=1 for exactly LAT cycles (N+1..N+LAT); md_cnt decrements at each edge.
  - In cycle N+LAT (md_cnt==1): md_done=1, hi_we=1, lo_we=1.
  - At the next edge: state IDLE, md_cnt=0.
- mthi/mtlo in IDLE: hi_we (mthi) or lo_we (mtlo) is 1 in cycle N only. No busy, no start, no done.
- d_stall = d_md_use && (md_busy || md_start). This prevents back-to-back md issue; mfhi/mflo never read stale HI/LO.
- Back-to-back: a new op may be accepted in the cycle after the last busy cycle. No bubble beyond the stall.
- e_op_valid while md_busy, or e_op==111 while e_op_valid:
  - The op is ignored; state, counter and enables are unchanged.
  - md_err is set and held until reset.
- e_op==000 or e_op_valid==0: no action.
- md_busy, md_done, hi_we/lo_we (mult/div) and md_cnt are decoded from registered state. Only md_start, md_func, mthi/mtlo enables and the md_start term of d_stall are combinational from inputs.

Optional Feature:
MD_DIV0_SKIP_EN
- Defined: div/divu accepted with e_rt_zero=1 loads md_cnt=1. md_busy is 1 for one cycle (N+1), md_done=1 in N+1, and hi_we=lo_we=0 (HI/LO preserved).
- Undefined: e_rt_zero is ignored; division by zero runs the full DIV_LAT and commits whatever the datapath produces.

Test Plan:
- Reset: hold reset=0 with e_op_valid=1, e_op=001 -> all outputs 0, md_cnt=0. Release; idle inputs -> outputs stay 0.
- mult at cycle 10 -> md_start=1, md_func=001 in cycle 10; md_busy=1 in cycles 11–15; md_cnt 5,4,3,2,1; md_done=hi_we=lo_we=1 in cycle 15; idle in cycle 16.
- divu at cycle 20 with d_md_use=1 (mflo in D) throughout -> d_stall=1 in cycles 20–30; d_stall=0 in cycle 31; md_done in cycle 30.
- mthi at cycle 5 -> hi_we=1, lo_we=0 in cycle 5 only; md_busy=0; md_start=0. mtlo -> lo_we only.
- mult at cycle 0, then e_op_valid=1 with e_op=011 at cycle 2 -> op ignored; md_err=1 from cycle 3, held; md_done still in cycle 5.
- div at cycle 0; reset=0 asynchronously at cycle 4 -> outputs 0 immediately, no hi_we afterwards. With MD_DIV0_SKIP_EN, div with e_rt_zero=1 at cycle 0 -> busy in cycle 1 only, hi_we=lo_we=0.

Source files
------------

// File: rtl/md_issue_if.sv
// md_issue_if: bundles the EX-stage request, D-stage hazard input and the
// multiply/divide datapath controls around md_issue_ctrl.
//
// Signals:
//   e_op_valid, e_op[2:0], e_rt_zero : EX-stage md-class request
//   d_md_use                         : D-stage instruction is md-class
//   md_start, md_func[2:0]           : start pulse and function to datapath
//   md_busy, md_done, md_cnt         : sequencing status
//   d_stall                          : stall request to the stall unit
//   hi_we, lo_we                     : HI/LO commit enables
//   md_err                           : sticky protocol error flag
//
// Handshake: e_op_valid qualifies e_op for one cycle. There is no ready
// signal. A request is taken exactly when md_start is high in that same
// cycle (or, for mthi/mtlo, when hi_we/lo_we is high). A request that
// arrives while md_busy is high is dropped and raises md_err. The producer
// avoids this by honouring d_stall, which is asserted from the start cycle
// through the last busy cycle while an md-class instruction waits in D.
//
// Modports: master = EX/D-stage side, slave = the issue controller.
interface md_issue_if #(
  parameter int CNT_W = 4
);
  logic             e_op_valid;
  logic [2:0]       e_op;
  logic             e_rt_zero;
  logic             d_md_use;
  logic             md_start;
  logic [2:0]       md_func;
  logic             md_busy;
  logic             d_stall;
  logic             hi_we;
  logic             lo_we;
  logic             md_done;
  logic [CNT_W-1:0] md_cnt;
  logic             md_err;

  modport master (
    output e_op_valid, e_op, e_rt_zero, d_md_use,
    input  md_start, md_func, md_busy, d_stall, hi_we, lo_we,
           md_done, md_cnt, md_err
  );

  modport slave (
    input  e_op_valid, e_op, e_rt_zero, d_md_use,
    output md_start, md_func, md_busy, d_stall, hi_we, lo_we,
           md_done, md_cnt, md_err
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue and sequencing controller for the shared
// multiply/divide unit. It accepts mult/multu/div/divu from EX, pulses the
// datapath start, counts out the fixed latency and commits HI/LO on the last
// busy cycle. mthi/mtlo commit immediately with no busy period.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset (0 = reset)
//   bus          : md_issue_if.slave (request, status and enables)
//   dbg_state_o  : current FSM state (0 = IDLE, 1 = RUN)
//
// Optional feature macro: MD_DIV0_SKIP_EN
//   When defined, a div/divu with a zero divisor finishes after one busy
//   cycle and leaves HI/LO untouched. When undefined, e_rt_zero is ignored.
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         reset,
  md_issue_if.slave    bus,
  output logic         dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSV   = 3'b111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             commit;

  logic             op_valid;
  logic             is_mul, is_div, is_mt;
  logic             in_idle;
  logic             accept;
  logic             mt_we;
  logic             err_evt;
  logic             done;

`ifdef MD_DIV0_SKIP_EN
  // Remembers whether the running op should write HI/LO when it finishes.
  logic commit_q, commit_d;
  assign commit = commit_q;
`else
  logic unused_rt_zero;
  assign unused_rt_zero = bus.e_rt_zero;
  assign commit         = 1'b1;
`endif

  // Request decode. Qualified by reset so nothing combinational leaks out
  // while reset is held.
  always_comb begin
    op_valid = bus.e_op_valid && reset;
    is_mul   = (bus.e_op == OP_MULT) || (bus.e_op == OP_MULTU);
    is_div   = (bus.e_op == OP_DIV)  || (bus.e_op == OP_DIVU);
    is_mt    = (bus.e_op == OP_MTHI) || (bus.e_op == OP_MTLO);
    in_idle  = (state_q == IDLE);
    accept   = op_valid && in_idle && (is_mul || is_div);
    mt_we    = op_valid && in_idle && is_mt;
    // Any real op while busy, or the reserved encoding, is dropped and flagged.
    err_evt  = op_valid && ((bus.e_op == OP_RSV) ||
                            (!in_idle && (bus.e_op != OP_NONE)));
    done     = (state_q == RUN) && (cnt_q == CNT_W'(1));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q || err_evt;
`ifdef MD_DIV0_SKIP_EN
    commit_d = commit_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
`ifdef MD_DIV0_SKIP_EN
          commit_d = 1'b1;
          if (is_div && bus.e_rt_zero) begin
            cnt_d    = CNT_W'(1);
            commit_d = 1'b0;
          end
`endif
        end
      end
      RUN: begin
        // cnt_q <= 1 also covers an unreachable zero count, so RUN cannot stick.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MD_DIV0_SKIP_EN
      commit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MD_DIV0_SKIP_EN
      commit_q <= commit_d;
`endif
    end
  end

  // Outputs: status from registered state, start/func/mt enables from inputs.
  always_comb begin
    bus.md_start = accept;
    bus.md_func  = accept ? bus.e_op : OP_NONE;
    bus.md_busy  = (state_q == RUN);
    bus.d_stall  = bus.d_md_use && ((state_q == RUN) || accept);
    bus.md_done  = done;
    bus.hi_we    = (done && commit) || (mt_we && (bus.e_op == OP_MTHI));
    bus.lo_we    = (done && commit) || (mt_we && (bus.e_op == OP_MTLO));
    bus.md_cnt   = cnt_q;
    bus.md_err   = err_q;
    dbg_state_o  = state_q;
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;

  localparam int CNT_W = 4;
  localparam int OW    = 14;

  logic clk;
  logic reset;
  logic dbg_state;

  md_issue_if #(.CNT_W(CNT_W)) bus ();

  md_issue_ctrl #(
    .MULT_LAT (5),
    .DIV_LAT  (10),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {start, func, busy, stall, hi_we, lo_we, done, cnt, err}
  logic [OW-1:0] obs;
  assign obs = {bus.md_start, bus.md_func, bus.md_busy, bus.d_stall,
                bus.hi_we, bus.lo_we, bus.md_done, bus.md_cnt, bus.md_err};

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_v;
  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [OW-1:0] ev(logic st, logic [2:0] fn, logic bz,
                                       logic sl, logic hw, logic lw,
                                       logic dn, logic [CNT_W-1:0] cnt,
                                       logic er);
    return {st, fn, bz, sl, hw, lw, dn, cnt, er};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [2:0] op, input logic rz,
                       input logic du);
    @(posedge clk);
    #1;
    bus.e_op_valid = v;
    bus.e_op       = op;
    bus.e_rt_zero  = rz;
    bus.d_md_use   = du;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset          = 1'b0;
    bus.e_op_valid = 1'b1;
    bus.e_op       = 3'b001;
    bus.e_rt_zero  = 1'b0;
    bus.d_md_use   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back('0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h expected %h", obs, exp_v);
    end
    tests_run++;
    if (dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected 0", dbg_state);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.e_op_valid = 1'b0;
    bus.e_op       = 3'b000;
    bus.d_md_use   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) drive(0, 3'b000, 0, 0);
      exp_q.push_back('0);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL reset_idle cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_mult();
    for (int k = 0; k <= 6; k++) begin
      if (k == 0) begin
        drive(1, 3'b001, 0, 0);
        exp_q.push_back(ev(1, 3'b001, 0, 0, 0, 0, 0, 4'd0, 0));
      end else begin
        drive(0, 3'b000, 0, 0);
        if (k <= 5)
          exp_q.push_back(ev(0, 3'b000, 1, 0, k == 5, k == 5, k == 5,
                             4'(6 - k), 0));
        else
          exp_q.push_back('0);
      end
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL mult cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  // divu with an mflo waiting in D for the whole operation.
  task automatic test_divu_stall();
    for (int k = 0; k <= 11; k++) begin
      if (k == 0) begin
        drive(1, 3'b100, 0, 1);
        exp_q.push_back(ev(1, 3'b100, 0, 1, 0, 0, 0, 4'd0, 0));
      end else begin
        drive(0, 3'b000, 0, 1);
        if (k <= 10)
          exp_q.push_back(ev(0, 3'b000, 1, 1, k == 10, k == 10, k == 10,
                             4'(11 - k), 0));
        else
          exp_q.push_back('0);
      end
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL divu_stall cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin
          drive(1, 3'b101, 0, 0);
          exp_q.push_back(ev(0, 3'b000, 0, 0, 1, 0, 0, 4'd0, 0));
        end
        2: begin
          drive(1, 3'b110, 0, 0);
          exp_q.push_back(ev(0, 3'b000, 0, 0, 0, 1, 0, 4'd0, 0));
        end
        default: begin
          drive(0, 3'b000, 0, 0);
          exp_q.push_back('0);
        end
      endcase
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL mthi_mtlo cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  // mult then div issued in the cycle right after the last busy cycle.
  task automatic test_back_to_back();
    for (int k = 0; k <= 17; k++) begin
      if (k == 0) begin
        drive(1, 3'b010, 0, 0);
        exp_q.push_back(ev(1, 3'b010, 0, 0, 0, 0, 0, 4'd0, 0));
      end else if (k <= 5) begin
        drive(0, 3'b000, 0, 0);
        exp_q.push_back(ev(0, 3'b000, 1, 0, k == 5, k == 5, k == 5,
                           4'(6 - k), 0));
      end else if (k == 6) begin
        drive(1, 3'b011, 0, 0);
        exp_q.push_back(ev(1, 3'b011, 0, 0, 0, 0, 0, 4'd0, 0));
      end else if (k <= 16) begin
        drive(0, 3'b000, 0, 0);
        exp_q.push_back(ev(0, 3'b000, 1, 0, k == 16, k == 16, k == 16,
                           4'(17 - k), 0));
      end else begin
        drive(0, 3'b000, 0, 0);
        exp_q.push_back('0);
      end
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  // A valid op while busy is dropped; md_err rises next cycle and sticks.
  task automatic test_busy_err();
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) begin
        drive(1, 3'b001, 0, 0);
        exp_q.push_back(ev(1, 3'b001, 0, 0, 0, 0, 0, 4'd0, 0));
      end else if (k == 2) begin
        drive(1, 3'b011, 0, 0);
        exp_q.push_back(ev(0, 3'b000, 1, 0, 0, 0, 0, 4'd4, 0));
      end else begin
        drive(0, 3'b000, 0, 0);
        if (k <= 5)
          exp_q.push_back(ev(0, 3'b000, 1, 0, k == 5, k == 5, k == 5,
                             4'(6 - k), k >= 3));
        else
          exp_q.push_back(ev(0, 3'b000, 0, 0, 0, 0, 0, 4'd0, 1));
      end
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL busy_err cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
    // Only reset clears the sticky flag.
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    exp_q.push_back('0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL err_clear: got %h expected %h", obs, exp_v);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // e_op 000 with valid does nothing; reserved 111 sets md_err only.
  task automatic test_reserved();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin
          drive(1, 3'b000, 0, 1);
          exp_q.push_back('0);
        end
        1: begin
          drive(1, 3'b111, 0, 0);
          exp_q.push_back('0);
        end
        default: begin
          drive(0, 3'b000, 0, 0);
          exp_q.push_back(ev(0, 3'b000, 0, 0, 0, 0, 0, 4'd0, 1));
        end
      endcase
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL reserved cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  // div in flight, reset asserted mid-cycle: outputs clear at once, no commit.
  task automatic test_async_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      if (k == 0) begin
        drive(1, 3'b011, 0, 0);
        exp_q.push_back(ev(1, 3'b011, 0, 0, 0, 0, 0, 4'd0, 0));
      end else begin
        drive(0, 3'b000, 0, 0);
        exp_q.push_back(ev(0, 3'b000, 1, 0, 0, 0, 0, 4'(11 - k), 0));
      end
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL async_pre cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    exp_q.push_back('0);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL async_now: got %h expected %h", obs, exp_v);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(0, 3'b000, 0, 0);
      exp_q.push_back('0);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL async_post cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  // div with a zero divisor.
  task automatic test_div_zero();
    int last;
`ifdef MD_DIV0_SKIP_EN
    last = 1;
`else
    last = 10;
`endif
    for (int k = 0; k <= last + 1; k++) begin
      if (k == 0) begin
        drive(1, 3'b011, 1, 0);
        exp_q.push_back(ev(1, 3'b011, 0, 0, 0, 0, 0, 4'd0, 0));
      end else begin
        drive(0, 3'b000, 0, 0);
        if (k <= last) begin
`ifdef MD_DIV0_SKIP_EN
          exp_q.push_back(ev(0, 3'b000, 1, 0, 0, 0, 1, 4'd1, 0));
`else
          exp_q.push_back(ev(0, 3'b000, 1, 0, k == 10, k == 10, k == 10,
                             4'(11 - k), 0));
`endif
        end else begin
          exp_q.push_back('0);
        end
      end
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL div_zero cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  // Random idle/mthi/mtlo traffic: only the decoded enable may fire.
  task automatic test_random_mt();
    logic [2:0] op;
    logic       v;
    for (int k = 0; k < 20; k++) begin
      v  = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(5, 6));
      drive(v, op, 1'($urandom_range(0, 1)), 0);
      exp_q.push_back(ev(0, 3'b000, 0, 0, v && op == 3'b101,
                         v && op == 3'b110, 0, 4'd0, 0));
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL random_mt cyc %0d: got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mult();
    test_divu_stall();
    test_mthi_mtlo();
    test_random_mt();
    test_back_to_back();
    test_div_zero();
    test_busy_err();
    test_reserved();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
